mag_cmp_monitor: RTL and testbench
==================================

Name: mag_cmp_monitor

Overview:
- Sequential stage directly downstream of the 2-bit magnitude comparator.
- Samples the comparator's A>B / A==B / A<B flags when a strobe is high and keeps saturating event counts for each outcome.
- Tracks consecutive same-outcome runs with a small FSM and raises trend alarms when a run reaches a threshold.
- Flags any non-one-hot flag combination as a protocol error.

Parameters:
- CNT_W, 8: width of each outcome counter; counters saturate at 2^CNT_W-1.
- RUN_LEN, 4: number of consecutive same-class samples needed to raise an alarm; legal range 2..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; flags are taken on any rising edge where in_valid=1.
- in_gt  in  1  comparator A>B flag (c0).
- in_eq  in  1  comparator A==B flag (c1).
- in_lt  in  1  comparator A<B flag (c2).
- clear  in  1  synchronous clear of all monitor state.
- out_valid  out  1  one-cycle pulse on the cycle after each accepted legal sample.
- last_class  out  2  class of the last accepted sample: 00 none, 01 GT, 10 EQ, 11 LT.
- gt_count  out  CNT_W  saturating count of accepted GT samples.
- eq_count  out  CNT_W  saturating count of accepted EQ samples.
- lt_count  out  CNT_W  saturating count of accepted LT samples.
- run_len  out  8  length of the current same-class run; saturates at RUN_LEN.
- gt_alarm  out  1  level: GT run active and run_len >= RUN_LEN.
- lt_alarm  out  1  level: LT run active and run_len >= RUN_LEN.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1): all outputs and state go to 0; FSM=IDLE; last_class=00. Reset mid-run discards the run completely.
- Priority per edge: rst > clear > sample.
- clear=1: same result as reset but synchronous, including err. A sample presented in the same cycle is discarded and out_valid stays 0 next cycle.
- Legal sample: in_valid=1 and exactly one of gt/eq/lt is 1.
- Illegal sample: in_valid=1 and zero, two or three flags set.
  - err is set (sticky until rst or clear).
  - Counters, run_len, FSM and last_class are unchanged; no out_valid.
- in_valid=0 cycles:
  - Inputs are ignored.
  - A run is not broken by idle gaps.
  - out_valid=0.
- Latency: all outputs are registered and reflect the accepted sample on the cycle after acceptance (1-cycle latency).
- Counters: the matching count increments by 1 unless already at 2^CNT_W-1, where it holds. No wrap-around.
- FSM states: IDLE, RUN_GT, RUN_EQ, RUN_LT.
  - IDLE --legal X--> RUN_X, run_len=1.
  - RUN_X --legal X--> RUN_X, run_len=min(run_len+1, RUN_LEN).
  - RUN_X --legal Y (Y!=X)--> RUN_Y, run_len=1.
  - Illegal samples and idle cycles: stay in the current state.
- Alarms:
  - gt_alarm = (state==RUN_GT) && (run_len==RUN_LEN); lt_alarm is the mirror for RUN_LT.
  - EQ runs never alarm.
  - An alarm drops on the cycle after the first differing legal sample.
- gt_alarm and lt_alarm are never both 1.

Decomposition:
- Package mag_cmp_pkg holds:
  - run_state_t enum (IDLE, RUN_GT, RUN_EQ, RUN_LT);
  - cls_t 2-bit class constants (CLS_NONE=0, CLS_GT=1, CLS_EQ=2, CLS_LT=3);
  - a function flags_to_cls returning cls plus a legal bit.
- Sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output q, saturating) is instantiated three times for the outcome counters.

Test Plan:
- Reset/idle: assert rst mid-stream, then hold in_valid=0 for 5 cycles -> all counts 0, run_len=0, last_class=00, alarms 0, err 0, out_valid never pulses.
- GT run to alarm (RUN_LEN=4): present 4 GT samples with one idle cycle between the 2nd and 3rd -> gt_count=4, run_len=4, gt_alarm=1 on the cycle after the 4th sample; out_valid pulses exactly 4 times.
- Run break: after the GT alarm, send 1 LT then 1 EQ -> gt_alarm=0 and state RUN_LT with run_len=1; then RUN_EQ with run_len=1; lt_count=1, eq_count=1, last_class=10.
- Illegal flags: send gt=1,lt=1 with in_valid=1, then send gt=eq=lt=0 with in_valid=1 -> err=1 and stays 1; counters, run_len and last_class unchanged; no out_valid.
- Saturation (CNT_W=3): 10 EQ samples -> eq_count holds at 7; run_len holds at 4; lt_alarm and gt_alarm stay 0.
- Clear collision: assert clear together with a legal GT sample while err=1 and counts are nonzero -> next cycle all counts 0, err=0, FSM IDLE, out_valid=0.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types for the magnitude-comparator monitor.
// Class codes double as the run-state encoding.
package mag_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_GT = 2'd1,
      RUN_EQ = 2'd2,
      RUN_LT = 2'd3
   } run_state_t;

   typedef logic [1:0] cls_t;

   localparam cls_t CLS_NONE = 2'd0;
   localparam cls_t CLS_GT   = 2'd1;
   localparam cls_t CLS_EQ   = 2'd2;
   localparam cls_t CLS_LT   = 2'd3;

   typedef struct packed {
      logic legal;
      cls_t cls;
   } cls_res_t;

   function automatic cls_res_t flags_to_cls(
      input logic gt,
      input logic eq,
      input logic lt
   );
      cls_res_t r;
      r.legal = 1'b1;
      r.cls   = CLS_NONE;
      case ({gt, eq, lt})
         3'b100:  r.cls = CLS_GT;
         3'b010:  r.cls = CLS_EQ;
         3'b001:  r.cls = CLS_LT;
         default: r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mag_cmp_monitor_sat_counter.sv
// Saturating up-counter with async reset and sync clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/mag_cmp_monitor.sv
// Monitor for comparator flags: outcome counts, run tracking,
// trend alarms and sticky protocol-error detection.
module mag_cmp_monitor
   import mag_cmp_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int RUN_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_gt,
   input  logic             in_eq,
   input  logic             in_lt,
   input  logic             clear,
   output logic             out_valid,
   output logic [1:0]       last_class,
   output logic [CNT_W-1:0] gt_count,
   output logic [CNT_W-1:0] eq_count,
   output logic [CNT_W-1:0] lt_count,
   output logic [7:0]       run_len,
   output logic             gt_alarm,
   output logic             lt_alarm,
   output logic             err
);

   localparam logic [7:0] RL = 8'(RUN_LEN);

   cls_res_t   res;
   logic       acc;
   run_state_t state_q, state_d;
   logic [7:0] run_q, run_d;
   cls_t       last_q;
   logic       ov_q, err_q, gta_q, lta_q;

   assign res = flags_to_cls(in_gt, in_eq, in_lt);
   assign acc = in_valid && res.legal && !clear;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (acc) begin
         case (res.cls)
            CLS_GT:  state_d = RUN_GT;
            CLS_EQ:  state_d = RUN_EQ;
            CLS_LT:  state_d = RUN_LT;
            default: state_d = IDLE;
         endcase
         if (state_d != state_q) begin
            run_d = 8'd1;
         end else if (run_q != RL) begin
            run_d = run_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         run_q   <= '0;
         last_q  <= CLS_NONE;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
         gta_q   <= 1'b0;
         lta_q   <= 1'b0;
      end else if (clear) begin
         state_q <= IDLE;
         run_q   <= '0;
         last_q  <= CLS_NONE;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
         gta_q   <= 1'b0;
         lta_q   <= 1'b0;
      end else begin
         ov_q    <= acc;
         state_q <= state_d;
         run_q   <= run_d;
         gta_q   <= (state_d == RUN_GT) && (run_d == RL);
         lta_q   <= (state_d == RUN_LT) && (run_d == RL);
         if (acc) begin
            last_q <= res.cls;
         end else if (in_valid) begin
            err_q <= 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_gt (
      .clk(clk), .rst(rst), .clr(clear),
      .inc(acc && (res.cls == CLS_GT)), .q(gt_count)
   );

   sat_counter #(.W(CNT_W)) u_eq (
      .clk(clk), .rst(rst), .clr(clear),
      .inc(acc && (res.cls == CLS_EQ)), .q(eq_count)
   );

   sat_counter #(.W(CNT_W)) u_lt (
      .clk(clk), .rst(rst), .clr(clear),
      .inc(acc && (res.cls == CLS_LT)), .q(lt_count)
   );

   assign out_valid  = ov_q;
   assign last_class = last_q;
   assign run_len    = run_q;
   assign gt_alarm   = gta_q;
   assign lt_alarm   = lta_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mag_cmp_monitor.sv
// Scoreboard bench: driver pushes expected snapshots, monitor compares.
module tb_mag_cmp_monitor;

   localparam int CW = 3;
   localparam int RL = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_gt = 1'b0, in_eq = 1'b0, in_lt = 1'b0;
   logic clear = 1'b0;
   logic out_valid;
   logic [1:0] last_class;
   logic [CW-1:0] gt_count, eq_count, lt_count;
   logic [7:0] run_len;
   logic gt_alarm, lt_alarm, err;

   always #5 clk = ~clk;

   mag_cmp_monitor #(.CNT_W(CW), .RUN_LEN(RL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_gt(in_gt), .in_eq(in_eq), .in_lt(in_lt),
      .clear(clear), .out_valid(out_valid),
      .last_class(last_class), .gt_count(gt_count),
      .eq_count(eq_count), .lt_count(lt_count),
      .run_len(run_len), .gt_alarm(gt_alarm),
      .lt_alarm(lt_alarm), .err(err)
   );

   typedef struct {
      int ov, last, gc, ec, lc, rl, ga, la, er;
   } snap_t;

   snap_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // reference model: counts per class, current run class/length
   int cnt[4];
   int run_cls, run_n, last_c, err_m, ov_m;

   task automatic model_step(input bit v, g, e, l, c, r);
      int n;
      int k;
      if (r || c) begin
         cnt = '{0, 0, 0, 0};
         run_cls = 0; run_n = 0; last_c = 0;
         err_m = 0; ov_m = 0;
      end else if (v) begin
         n = int'(g) + int'(e) + int'(l);
         if (n != 1) begin
            err_m = 1;
            ov_m = 0;
         end else begin
            k = g ? 1 : (e ? 2 : 3);
            if (cnt[k] < CMAX) cnt[k]++;
            if (k == run_cls) run_n = (run_n < RL) ? run_n + 1 : RL;
            else run_n = 1;
            run_cls = k;
            last_c = k;
            ov_m = 1;
         end
      end else begin
         ov_m = 0;
      end
   endtask

   task automatic cyc(input bit v, g, e, l, c, r);
      snap_t s;
      @(negedge clk);
      in_valid = v; in_gt = g; in_eq = e; in_lt = l;
      clear = c; rst = r;
      model_step(v, g, e, l, c, r);
      s.ov = ov_m; s.last = last_c;
      s.gc = cnt[1]; s.ec = cnt[2]; s.lc = cnt[3];
      s.rl = run_n;
      s.ga = (run_cls == 1 && run_n == RL) ? 1 : 0;
      s.la = (run_cls == 3 && run_n == RL) ? 1 : 0;
      s.er = err_m;
      exp_q.push_back(s);
   endtask

   task automatic chk(input string nm, input int act, input int ex);
      checks++;
      if (act != ex) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, ex);
      end
   endtask

   initial begin : monitor
      snap_t s;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            chk("out_valid", int'(out_valid), s.ov);
            chk("err", int'(err), s.er);
            chk("gt_alarm", int'(gt_alarm), s.ga);
            chk("lt_alarm", int'(lt_alarm), s.la);
            if (gt_alarm && lt_alarm) chk("both_alarms", 1, 0);
            if (out_valid || s.ov != 0 || s.er != 0 || s.last == 0) begin
               chk("last_class", int'(last_class), s.last);
               chk("gt_count", int'(gt_count), s.gc);
               chk("eq_count", int'(eq_count), s.ec);
               chk("lt_count", int'(lt_count), s.lc);
               chk("run_len", int'(run_len), s.rl);
            end
         end
      end
   end

   initial begin : driver
      int m;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 1);
      repeat (5) cyc(0, 1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      repeat (10) cyc(1, 0, 1, 0, 0, 0);
      repeat (5) cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         bit v, g, e, l, c, r;
         v = ($urandom_range(3) != 0);
         m = $urandom_range(9);
         g = (m < 4); e = (m == 4 || m == 5); l = (m >= 6 && m <= 8);
         if (m == 9) begin
            g = 1'($urandom); e = 1'($urandom); l = 1'($urandom);
         end
         c = ($urandom_range(49) == 0);
         r = ($urandom_range(79) == 0);
         if ($urandom_range(99) < 3) v = 1;
         if (i % 97 > 60 && i % 97 < 75) begin
            v = 1; g = 0; e = 0; l = 1; c = 0; r = 0;
         end
         cyc(v, g, e, l, c, r);
      end
      cyc(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
